// File: rtl/alu_cmd_issuer_if.sv
// Command and response channels between a command source and alu_cmd_issuer.
// master = command source / response consumer, slave = the issuer.
interface alu_cmd_issuer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_error;
   logic [1:0] rsp_op;
   logic       rsp_mismatch;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_op, rsp_mismatch
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_op, rsp_mismatch
   );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands in a FIFO, drives the ALU from registers and returns captured results.
// Define ALU_ISSUER_SELFCHECK_EN to add the registered result self-check on rsp_mismatch.
module alu_cmd_issuer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   alu_cmd_issuer_if.slave  bus,
   output logic [3:0]       alu_in1,
   output logic [3:0]       alu_in2,
   output logic [1:0]       alu_opcode,
   input  logic [3:0]       alu_out,
   input  logic             alu_error,
   output logic [CNT_W-1:0] err_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   typedef struct packed {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   cmd_t             mem_q [DEPTH];
   cmd_t             cmd_in;
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
   logic             iss_valid_q, iss_valid_d;
   logic [3:0]       alu_in1_q, alu_in1_d;
   logic [3:0]       alu_in2_q, alu_in2_d;
   logic [1:0]       alu_opcode_q, alu_opcode_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [3:0]       rsp_data_q, rsp_data_d;
   logic             rsp_error_q, rsp_error_d;
   logic [1:0]       rsp_op_q, rsp_op_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             full, empty, push, pop, advance;

   // Ready looks only at registered occupancy, so a full FIFO refuses a push even while popping.
   assign full    = (fifo_cnt_q == FULL_CNT);
   assign empty   = (fifo_cnt_q == '0);
   assign push    = bus.cmd_valid && !full;
   assign advance = iss_valid_q && (!rsp_valid_q || bus.rsp_ready);
   assign pop     = !empty && (!iss_valid_q || advance);
   assign cmd_in  = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_in;
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_cnt_d   = fifo_cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      iss_valid_d  = iss_valid_q;
      alu_in1_d    = alu_in1_q;
      alu_in2_d    = alu_in2_q;
      alu_opcode_d = alu_opcode_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_error_d  = rsp_error_q;
      rsp_op_d     = rsp_op_q;
      err_count_d  = err_count_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

      if (pop) begin
         rd_ptr_d     = rd_ptr_q + PTR_W'(1);
         iss_valid_d  = 1'b1;
         alu_in1_d    = head.a;
         alu_in2_d    = head.b;
         alu_opcode_d = head.op;
      end else if (advance) begin
         iss_valid_d = 1'b0;
      end

      // The ALU is combinational: its output for the issued operands is captured on advance.
      if (advance) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = alu_out;
         rsp_error_d = alu_error;
         rsp_op_d    = alu_opcode_q;
         if (alu_error) err_count_d = sat_inc(err_count_q);
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         iss_valid_q  <= 1'b0;
         alu_in1_q    <= '0;
         alu_in2_q    <= '0;
         alu_opcode_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_error_q  <= 1'b0;
         rsp_op_q     <= '0;
         err_count_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         iss_valid_q  <= iss_valid_d;
         alu_in1_q    <= alu_in1_d;
         alu_in2_q    <= alu_in2_d;
         alu_opcode_q <= alu_opcode_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_error_q  <= rsp_error_d;
         rsp_op_q     <= rsp_op_d;
         err_count_q  <= err_count_d;
      end
   end

`ifdef ALU_ISSUER_SELFCHECK_EN
   // Returns {error, result} as a correct 4-bit ALU would for the issued command.
   function automatic logic [4:0] alu_expect(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
      logic [3:0] r;
      logic       e;
      r = '0;
      e = 1'b0;
      case (op)
         2'b00: begin r = a + b; e = ~(a[3] ^ b[3]) & (a[3] ^ r[3]); end
         2'b01: begin r = a - b; e =  (a[3] ^ b[3]) & (a[3] ^ r[3]); end
         2'b10: r = ~(a & b);
         default: r = a ^ b;
      endcase
      return {e, r};
   endfunction

   logic [4:0] expect_w;
   logic       mismatch_q, mismatch_d;

   always_comb begin
      expect_w   = alu_expect(alu_in1_q, alu_in2_q, alu_opcode_q);
      mismatch_d = mismatch_q;
      if (advance) mismatch_d = (expect_w[3:0] != alu_out) || (expect_w[4] != alu_error);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mismatch_q <= 1'b0;
      else     mismatch_q <= mismatch_d;
   end

   assign bus.rsp_mismatch = mismatch_q;
`else
   assign bus.rsp_mismatch = 1'b0;
`endif

   assign bus.cmd_ready = !full;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_error = rsp_error_q;
   assign bus.rsp_op    = rsp_op_q;
   assign alu_in1       = alu_in1_q;
   assign alu_in2       = alu_in2_q;
   assign alu_opcode    = alu_opcode_q;
   assign err_count     = err_count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural ALU model plus a response scoreboard.
module tb_alu_cmd_issuer;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
`ifdef ALU_ISSUER_SELFCHECK_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] d;
      logic       e;
      logic [1:0] op;
      logic       mm;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [3:0]       alu_in1, alu_in2, alu_out;
   logic [1:0]       alu_opcode;
   logic             alu_error;
   logic [CNT_W-1:0] err_count;
   logic [4:0]       model_v, mon_v;
   logic             model_hit, mon_hit;
   exp_t             mon_e, mon_got;
   bit               corrupt_en = 1'b0;
   int               checks = 0;
   int               failures = 0;
   int               rsp_seen = 0;
   exp_t             exp_q[$];

   logic [1:0] bp_op [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
   logic [3:0] bp_a  [6] = '{4'h1, 4'h3, 4'h9, 4'h0, 4'h7, 4'h0};
   logic [3:0] bp_b  [6] = '{4'h1, 4'h5, 4'h3, 4'h0, 4'h7, 4'h8};

   alu_cmd_issuer_if bus();

   alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_error(alu_error), .err_count(err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
      logic [3:0] r;
      logic       e;
      e = 1'b0;
      case (op)
         2'b00: begin r = a + b; e = ~(a[3] ^ b[3]) & (a[3] ^ r[3]); end
         2'b01: begin r = a - b; e =  (a[3] ^ b[3]) & (a[3] ^ r[3]); end
         2'b10: r = ~(a & b);
         default: r = a ^ b;
      endcase
      return {e, r};
   endfunction

   // Combinational ALU; optionally flips bit0 of the result for ADD 2+2.
   always_comb begin
      model_v   = alu_ref(alu_in1, alu_in2, alu_opcode);
      model_hit = corrupt_en && alu_opcode == 2'b00 && alu_in1 == 4'd2 && alu_in2 == 4'd2;
      alu_out   = model_v[3:0] ^ {3'b000, model_hit};
      alu_error = model_v[4];
   end

   // Scoreboard: push on accepted command, pop and compare on consumed response.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            mon_v   = alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op);
            mon_hit = corrupt_en && bus.cmd_op == 2'b00 && bus.cmd_a == 4'd2 && bus.cmd_b == 4'd2;
            mon_e.d  = mon_v[3:0] ^ {3'b000, mon_hit};
            mon_e.e  = mon_v[4];
            mon_e.op = bus.cmd_op;
            mon_e.mm = SC && mon_hit;
            exp_q.push_back(mon_e);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected got data=%h err=%b op=%b", bus.rsp_data, bus.rsp_error, bus.rsp_op);
            end else begin
               mon_e = exp_q.pop_front();
               mon_got.d  = bus.rsp_data;
               mon_got.e  = bus.rsp_error;
               mon_got.op = bus.rsp_op;
               mon_got.mm = bus.rsp_mismatch;
               if (mon_got !== mon_e) begin
                  failures++;
                  $display("FAIL rsp_scoreboard got d=%h e=%b op=%b mm=%b exp d=%h e=%b op=%b mm=%b",
                           mon_got.d, mon_got.e, mon_got.op, mon_got.mm, mon_e.d, mon_e.e, mon_e.op, mon_e.mm);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      int   n;
      logic rdy;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      n = 0;
      do begin
         rdy = bus.cmd_ready;
         step();
         n++;
      end while (!rdy && n < 50);
      checks++;
      if (!rdy) begin
         failures++;
         $display("FAIL push_timeout cmd_ready=%b after %0d cycles, required 1", rdy, n);
      end
   endtask

   task automatic idle();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      end
      step();
      step();
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_a     = 4'h0;
      bus.cmd_b     = 4'h0;
      bus.rsp_ready = 1'b1;
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op, bus.rsp_mismatch,
           alu_in1, alu_in2, alu_opcode, err_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b d=%h e=%b op=%b cnt=%0d required all zero",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op, err_count);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cmd_ready got %b required 1", bus.cmd_ready);
      end
      @(posedge clk);
      step();
      rst = 1'b0;
   endtask

   task automatic test_latency();
      push_cmd(2'b00, 4'd3, 4'd4);
      idle();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL lat_edge1 rsp_valid=%b required 0", bus.rsp_valid);
      end
      step();
      checks++;
      if ({bus.rsp_valid, alu_in1, alu_in2, alu_opcode} !== {1'b0, 4'd3, 4'd4, 2'b00}) begin
         failures++;
         $display("FAIL lat_issue got v=%b in1=%h in2=%h op=%b required 0/3/4/00",
                  bus.rsp_valid, alu_in1, alu_in2, alu_opcode);
      end
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op} !== {1'b1, 4'h7, 1'b0, 2'b00}) begin
         failures++;
         $display("FAIL lat_rsp got v=%b d=%h e=%b op=%b required 1/7/0/00",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op);
      end
      step();
      checks++;
      if ({bus.rsp_valid, err_count} !== {1'b0, 8'd0}) begin
         failures++;
         $display("FAIL lat_after got v=%b cnt=%0d required 0/0", bus.rsp_valid, err_count);
      end
   endtask

   task automatic test_back_to_back();
      push_cmd(2'b00, 4'd7, 4'd1);
      push_cmd(2'b01, 4'd8, 4'd1);
      idle();
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op} !== {1'b1, 4'h8, 1'b1, 2'b00}) begin
         failures++;
         $display("FAIL b2b_first got v=%b d=%h e=%b op=%b required 1/8/1/00",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op);
      end
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op} !== {1'b1, 4'h7, 1'b1, 2'b01}) begin
         failures++;
         $display("FAIL b2b_second got v=%b d=%h e=%b op=%b required 1/7/1/01",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op);
      end
      step();
      checks++;
      if ({bus.rsp_valid, err_count} !== {1'b0, 8'd2}) begin
         failures++;
         $display("FAIL b2b_errcnt got v=%b cnt=%0d required 0/2", bus.rsp_valid, err_count);
      end
   endtask

   task automatic test_logic_ops();
      push_cmd(2'b10, 4'hF, 4'h5);
      push_cmd(2'b11, 4'hA, 4'h6);
      idle();
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op} !== {1'b1, 4'hA, 1'b0, 2'b10}) begin
         failures++;
         $display("FAIL nand got v=%b d=%h e=%b op=%b required 1/A/0/10",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op);
      end
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op} !== {1'b1, 4'hC, 1'b0, 2'b11}) begin
         failures++;
         $display("FAIL xor got v=%b d=%h e=%b op=%b required 1/C/0/11",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op);
      end
      step();
      checks++;
      if (err_count !== 8'd2) begin
         failures++;
         $display("FAIL logic_errcnt got %0d required 2", err_count);
      end
   endtask

   task automatic test_backpressure();
      int seen0;
      seen0 = rsp_seen;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_cmd(bp_op[i], bp_a[i], bp_b[i]);
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_full cmd_ready=%b required 0", bus.cmd_ready);
      end
      push_cmd_refused();
      idle();
      checks++;
      if (exp_q.size() != 6) begin
         failures++;
         $display("FAIL bp_accepted got %0d required 6", exp_q.size());
      end
      bus.rsp_ready = 1'b1;
      wait_drain();
      checks++;
      if (rsp_seen - seen0 != 6 || err_count !== 8'd4) begin
         failures++;
         $display("FAIL bp_drain got rsp=%0d cnt=%0d required 6/4", rsp_seen - seen0, err_count);
      end
   endtask

   task automatic push_cmd_refused();
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b10;
      bus.cmd_a     = 4'h0;
      bus.cmd_b     = 4'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_op} !== {1'b0, 1'b1, 4'h2, 2'b00}) begin
            failures++;
            $display("FAIL bp_stall got rdy=%b v=%b d=%h op=%b required 0/1/2/00",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_op);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen0;
      bit bad;
      bus.rsp_ready = 1'b0;
      push_cmd(2'b01, 4'h9, 4'h2);
      push_cmd(2'b00, 4'h7, 4'h7);
      push_cmd(2'b11, 4'h5, 4'h3);
      idle();
      step();
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_op, bus.rsp_mismatch,
           alu_in1, alu_in2, alu_opcode, err_count} !== '0) begin
         failures++;
         $display("FAIL midrst_outputs got v=%b d=%h e=%b in1=%h cnt=%0d required all zero",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, alu_in1, err_count);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_cmd_ready got %b required 1", bus.cmd_ready);
      end
      step();
      rst = 1'b0;
      seen0 = rsp_seen;
      bus.rsp_ready = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.rsp_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || rsp_seen != seen0) begin
         failures++;
         $display("FAIL midrst_dropped got stray=%b rsp=%0d required 0/0", bad, rsp_seen - seen0);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++) push_cmd(2'b00, 4'd7, 4'd1);
      idle();
      wait_drain();
      checks++;
      if (err_count !== 8'hFF) begin
         failures++;
         $display("FAIL sat_errcnt got %0d required 255", err_count);
      end
   endtask

   task automatic test_selfcheck();
      corrupt_en = 1'b1;
      push_cmd(2'b00, 4'd2, 4'd2);
      push_cmd(2'b00, 4'd5, 4'd6);
      idle();
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_mismatch} !== {1'b1, 4'h5, SC}) begin
         failures++;
         $display("FAIL sc_corrupt got v=%b d=%h mm=%b required 1/5/%b",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_mismatch, SC);
      end
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_mismatch} !== {1'b1, 4'hB, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sc_clean got v=%b d=%h e=%b mm=%b required 1/B/1/0",
                  bus.rsp_valid, bus.rsp_data, bus.rsp_error, bus.rsp_mismatch);
      end
      step();
      corrupt_en = 1'b0;
      checks++;
      if (err_count !== 8'hFF) begin
         failures++;
         $display("FAIL sc_errcnt_hold got %0d required 255", err_count);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_logic_ops();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_selfcheck();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 4-bit ALU operand/opcode interface.
- Accepts ALU commands (opcode plus two operands) through a valid/ready port and buffers them in a small FIFO.
- Drives the ALU's In1/In2/Opcode inputs from registers, captures ALU_Out/Error one cycle later, and returns results through a valid/ready response port.
- Keeps a saturating count of Error results; this block sits between the CPU control path (or a test sequencer) and the combinational ALU.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  2  00 ADD, 01 SUB, 10 NAND, 11 XOR.
- cmd_a  input  4  operand driven to ALU_In1.
- cmd_b  input  4  operand driven to ALU_In2.
- alu_in1  output  4  registered operand A to the ALU.
- alu_in2  output  4  registered operand B to the ALU.
- alu_opcode  output  2  registered opcode to the ALU.
- alu_out  input  4  combinational ALU result.
- alu_error  input  1  combinational ALU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  4  captured ALU result.
- rsp_error  output  1  captured ALU Error.
- rsp_op  output  2  opcode of the response.
- rsp_mismatch  output  1  self-check failure (see Optional Feature).
- err_count  output  CNT_W  saturating count of responses with rsp_error=1.

Behaviour:
- Reset (asynchronous, active-high): all of the following are cleared.
  - FIFO pointers and count = 0.
  - iss_valid = 0; alu_in1 = alu_in2 = 0; alu_opcode = 00.
  - rsp_valid = 0; rsp_data = 0; rsp_error = 0; rsp_op = 00; rsp_mismatch = 0.
  - err_count = 0.
  - In-flight commands are dropped. Reset mid-operation must not produce a response afterwards.
- Command port:
  - Push occurs when cmd_valid && cmd_ready on a rising edge.
  - cmd_ready = !full. It is registered-state based and is NOT pop-aware: when full, a same-cycle pop does not admit a push.
  - cmd_valid while cmd_ready=0 is ignored, and no state changes.
- Issue stage (register set alu_*, plus flag iss_valid):
  - Loads the FIFO head when the FIFO is non-empty and (!iss_valid || advance).
  - advance = iss_valid && (!rsp_valid || rsp_ready).
  - When the FIFO is empty, iss_valid clears on advance and alu_* hold their last values.
- Response stage:
  - On advance: rsp_data<=alu_out, rsp_error<=alu_error, rsp_op<=alu_opcode, rsp_valid<=1.
  - A response is consumed on rsp_valid && rsp_ready. Without a new advance, rsp_valid drops to 0.
  - Response fields hold stable while rsp_valid && !rsp_ready.
- Latency and throughput:
  - Command accepted at edge N, issued at edge N+1, rsp_valid=1 after edge N+2 when there is no backpressure.
  - Throughput is 1 response per cycle.
- Backpressure: rsp_ready=0 stalls the issue stage, then the FIFO. After DEPTH further accepted commands, cmd_ready=0.
- err_count increments by 1 on each advance with alu_error=1. It saturates at all-ones and never wraps.
- Pointer arithmetic is modulo DEPTH, with a separate count to distinguish full from empty.

Optional Feature:
- Macro: ALU_ISSUER_SELFCHECK_EN.
- Defined: on advance, the block computes the expected result from alu_in1, alu_in2 and alu_opcode and registers rsp_mismatch = (expected result != alu_out) || (expected error != alu_error). The expected values are:
  - ADD: (A+B) mod 16; error = ~(A3^B3) & (A3^R3).
  - SUB: (A-B) mod 16; error = (A3^B3) & (A3^R3).
  - NAND/XOR: bitwise result; error = 0.
- rsp_mismatch is valid with rsp_valid.
- Undefined: rsp_mismatch is tied to 0 and no checker logic is present.

Test Plan:
- Reset, then push ADD a=3 b=4 -> rsp_valid after 2 edges, rsp_data=7, rsp_error=0, rsp_op=00, err_count=0.
- Push ADD 7+1, then SUB 8-1 (8=-8), back-to-back, rsp_ready=1 -> in order: 8/error=1, then 7/error=1; err_count=2; one response per cycle.
- Push NAND a=F b=5, then XOR a=A b=6 -> rsp_data=A/error=0, then C/error=0.
- Hold rsp_ready=0 and push 6 commands -> cmd_ready falls after 6 accepted commands (1 response + 1 issue + 4 FIFO); first response stays stable; release rsp_ready -> all 6 returned in order.
- Assert rst mid-stream with 3 commands queued -> all outputs zero immediately; no response ever appears for the dropped commands.
- ALU_ISSUER_SELFCHECK_EN defined, bench corrupts alu_out bit0 on ADD 2+2 -> rsp_mismatch=1 with rsp_data=5; uncorrupted ADD -> rsp_mismatch=0.
